// File: rtl/wb_cache_pkg.sv
// wb_cache_pkg: shared types and width helpers for the
// set-associative write-back data cache.
package wb_cache_pkg;

  localparam int TAG_MAX = 32;

  typedef enum logic [1:0] {
    IDLE,
    TAG,
    WB,
    FILL
  } state_e;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TAG_MAX-1:0] tag;
  } line_meta_t;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(
    input int aw,
    input int sets,
    input int words
  );
    return aw - $clog2(sets) - $clog2(words);
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/wb_cache_lru.sv
// wb_cache_lru: per-set true-LRU ages; reports the
// oldest way of the addressed set as the victim.
module wb_cache_lru
  import wb_cache_pkg::*;
#(
  parameter  int SETS  = 8,
  parameter  int WAYS  = 2,
  localparam int IDX_W = idx_w(SETS),
  localparam int WAY_W = way_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] set_i,
  input  logic [WAY_W-1:0] hit_way_i,
  input  logic             upd_i,
  output logic [WAY_W-1:0] victim_o
);

  if (WAYS == 1) begin : g_one
    logic unused_in;
    assign unused_in = ^{clk, rst, set_i, hit_way_i, upd_i};
    assign victim_o  = '0;
  end else begin : g_lru
    logic [WAY_W-1:0] age_q [SETS][WAYS];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            age_q[s][w] <= WAY_W'(w);
      end else if (upd_i) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == hit_way_i)
            age_q[set_i][w] <= '0;
          else if (age_q[set_i][w] <
                   age_q[set_i][hit_way_i])
            age_q[set_i][w] <=
              age_q[set_i][w] + WAY_W'(1);
        end
      end
    end

    // ages of a set are always a permutation,
    // so exactly one way holds the maximum
    always_comb begin
      victim_o = '0;
      for (int w = 0; w < WAYS; w++)
        if (age_q[set_i][w] == WAY_W'(WAYS - 1))
          victim_o = WAY_W'(w);
    end
  end

endmodule

// File: rtl/wb_cache_assoc.sv
// wb_cache_assoc: N-way write-back, write-allocate cache.
// Optional perf counters under WB_CACHE_PERF_EN.
module wb_cache_assoc
  import wb_cache_pkg::*;
#(
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = 16,
  parameter  int WORDS  = 4,
  parameter  int SETS   = 8,
  parameter  int WAYS   = 2,
  localparam int OFF_W  = off_w(WORDS),
  localparam int IDX_W  = idx_w(SETS),
  localparam int TAG_W  = tag_w(ADDR_W, SETS, WORDS),
  localparam int LINE_W = DATA_W * WORDS,
  localparam int WAY_W  = way_w(WAYS),
  localparam int LA_W   = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [LA_W-1:0]   mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata
`ifdef WB_CACHE_PERF_EN
  ,
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss,
  output logic [31:0]       perf_wb
`endif
);

  state_e            state_q;
  logic              armed_q;
  logic              miss_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [WAY_W-1:0]  vic_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [LA_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;

  line_meta_t        meta_q [SETS][WAYS];
  logic [LINE_W-1:0] data_q [SETS][WAYS];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  assign off = addr_q[OFF_W-1:0];
  assign idx = addr_q[OFF_W +: IDX_W];
  assign tag = addr_q[ADDR_W-1 -: TAG_W];

  logic [WAYS-1:0]   hit_vec;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_any;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  lru_way;
  logic [WAY_W-1:0]  vic_way;
  logic [LINE_W-1:0] cur_line;
  logic [DATA_W-1:0] cur_word;
  logic              tag_hit;
  line_meta_t        vic_meta;

  // descending scan leaves the lowest invalid way
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = meta_q[idx][w].valid &&
                   (meta_q[idx][w].tag == TAG_MAX'(tag));
      if (hit_vec[w])
        hit_way = WAY_W'(w);
      if (!meta_q[idx][w].valid) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign hit      = |hit_vec;
  assign vic_way  = inv_any ? inv_way : lru_way;
  assign vic_meta = meta_q[idx][vic_way];
  assign cur_line = data_q[idx][hit_way];
  assign cur_word = cur_line[int'(off) * DATA_W +: DATA_W];
  assign tag_hit  = (state_q == TAG) && hit;

  assign req_ready = armed_q && (state_q == IDLE);
  assign rsp_valid = tag_hit;
  assign rsp_hit   = tag_hit && !miss_q;
  assign rsp_rdata = tag_hit ? cur_word : rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  wb_cache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk       (clk),
    .rst       (rst),
    .set_i     (idx),
    .hit_way_i (hit_way),
    .upd_i     (tag_hit),
    .victim_o  (lru_way)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      miss_q      <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      vic_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          meta_q[s][w] <= '0;
    end else begin
      armed_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (req_valid && armed_q) begin
            addr_q  <= req_addr;
            rd_q    <= req_rd;
            wdata_q <= req_wdata;
            miss_q  <= 1'b0;
            state_q <= TAG;
          end
        end
        TAG: begin
          if (hit) begin
            rdata_q <= cur_word;
            if (!rd_q)
              meta_q[idx][hit_way].dirty <= 1'b1;
            state_q <= IDLE;
          end else begin
            miss_q    <= 1'b1;
            vic_q     <= vic_way;
            mem_req_q <= 1'b1;
            if (vic_meta.valid && vic_meta.dirty) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {vic_meta.tag[TAG_W-1:0], idx};
              mem_wdata_q <= data_q[idx][vic_way];
              state_q     <= WB;
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag, idx};
              state_q    <= FILL;
            end
          end
        end
        WB: begin
          if (mem_ack) begin
            meta_q[idx][vic_q].dirty <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag, idx};
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            meta_q[idx][vic_q] <= '{
              valid: 1'b1,
              dirty: 1'b0,
              tag:   TAG_MAX'(tag)
            };
            mem_req_q <= 1'b0;
            state_q   <= TAG;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // line storage carries no reset
  always_ff @(posedge clk) begin
    if (tag_hit && !rd_q)
      data_q[idx][hit_way][int'(off) * DATA_W +: DATA_W]
        <= wdata_q;
    else if (state_q == FILL && mem_ack)
      data_q[idx][vic_q] <= mem_rdata;
  end

`ifdef WB_CACHE_PERF_EN
  logic [31:0] perf_hit_q;
  logic [31:0] perf_miss_q;
  logic [31:0] perf_wb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
      perf_wb_q   <= '0;
    end else begin
      if (rsp_hit && perf_hit_q != '1)
        perf_hit_q <= perf_hit_q + 32'd1;
      if (state_q == TAG && !hit && perf_miss_q != '1)
        perf_miss_q <= perf_miss_q + 32'd1;
      if (state_q == WB && mem_ack && perf_wb_q != '1)
        perf_wb_q <= perf_wb_q + 32'd1;
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
  assign perf_wb   = perf_wb_q;
`endif

endmodule

// File: tb/tb_wb_cache_assoc.sv
// tb_wb_cache_assoc: directed and random accesses against
// a set/way/recency model of the cache plus a memory array.
module tb_wb_cache_assoc;

  localparam int SETS = 8;
  localparam int WAYS = 2;
  localparam int LAW  = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rd = 1'b1;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [15:0] rsp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
`ifdef WB_CACHE_PERF_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
  logic [31:0] perf_wb;
`endif

  always #5 clk = ~clk;

  wb_cache_assoc dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_rdata (rsp_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef WB_CACHE_PERF_EN
    ,
    .perf_hit  (perf_hit),
    .perf_miss (perf_miss),
    .perf_wb   (perf_wb)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  bit          m_v   [SETS][WAYS];
  bit          m_d   [SETS][WAYS];
  logic [10:0] m_t   [SETS][WAYS];
  logic [63:0] m_l   [SETS][WAYS];
  int unsigned m_use [SETS][WAYS];
  int unsigned use_ctr;
  int          e_hit, e_miss, e_wb;
  logic [63:0] mem [1 << LAW];

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w]   = 1'b0;
        m_d[s][w]   = 1'b0;
        m_use[s][w] = 0;
      end
    use_ctr = 0;
    e_hit   = 0;
    e_miss  = 0;
    e_wb    = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);
  endtask

  task automatic access(
    input bit          rd,
    input logic [15:0] a,
    input logic [15:0] wd
  );
    int          s, off, hw, vw, nph, ph, dly, ack_c;
    logic [10:0] tg;
    bit          exp_hit, exp_wb, got, started, is_wb;
    logic [13:0] wb_a, fl_a;
    logic [63:0] wb_l, fl_l;
    logic [15:0] exp_rd;
    s   = int'(a[4:2]);
    off = int'(a[1:0]);
    tg  = a[15:5];
    hw  = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_v[s][w] && m_t[s][w] == tg) hw = w;
    exp_hit = (hw >= 0);
    exp_wb  = 1'b0;
    wb_a    = '0;
    wb_l    = '0;
    fl_a    = a[15:2];
    fl_l    = mem[fl_a];
    if (!exp_hit) begin
      vw = -1;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_v[s][w]) vw = w;
      if (vw < 0) begin
        vw = 0;
        for (int w = 1; w < WAYS; w++)
          if (m_use[s][w] < m_use[s][vw]) vw = w;
      end
      exp_wb = m_v[s][vw] && m_d[s][vw];
      wb_a   = {m_t[s][vw], a[4:2]};
      wb_l   = m_l[s][vw];
      e_miss++;
      if (exp_wb) e_wb++;
      m_v[s][vw] = 1'b1;
      m_d[s][vw] = 1'b0;
      m_t[s][vw] = tg;
      m_l[s][vw] = fl_l;
      hw = vw;
    end else begin
      e_hit++;
    end
    exp_rd = m_l[s][hw][off*16 +: 16];
    if (!rd) begin
      m_l[s][hw][off*16 +: 16] = wd;
      m_d[s][hw] = 1'b1;
    end
    use_ctr++;
    m_use[s][hw] = use_ctr;

    @(negedge clk);
    chk("req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_rd    = rd;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);

    nph     = exp_hit ? 0 : (exp_wb ? 2 : 1);
    ph      = 0;
    got     = 1'b0;
    started = 1'b0;
    ack_c   = -10;
    dly     = $urandom_range(0, 3);
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (rsp_valid) begin
        got = 1'b1;
        chk("rsp_after_mem", ph, nph);
        chk("rsp_hit", rsp_hit, exp_hit);
        if (exp_hit) chk("hit_latency", c, 0);
        else begin
          chk("miss_latency", c - ack_c, 1);
          chk("mem_req_drop", mem_req, 0);
        end
        if (rd) chk("rdata", rsp_rdata, exp_rd);
      end else if (ph < nph) begin
        if (mem_req) started = 1'b1;
        if (started) begin
          is_wb = exp_wb && ph == 0;
          chk("mem_req_hold", mem_req, 1);
          chk("mem_we", mem_we, is_wb);
          chk("mem_addr", mem_addr, is_wb ? wb_a : fl_a);
          if (is_wb) chk("wb_line", mem_wdata, wb_l);
          if (dly == 0) begin
            mem_ack = 1'b1;
            if (is_wb) mem[mem_addr] = mem_wdata;
            else mem_rdata = fl_l;
            ph++;
            ack_c = c;
            dly   = $urandom_range(0, 3);
          end else begin
            dly--;
          end
        end
      end else if (mem_req) begin
        chk("spurious_mem_req", mem_req, 0);
      end
    end
    mem_ack = 1'b0;
    if (!got) chk("rsp_timeout", got, 1);
  endtask

  task automatic reset_mid_fill(input logic [15:0] a);
    int c;
    c = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_rd    = 1'b1;
    req_addr  = a;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    while (!mem_req && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("midfill_req", mem_req, 1);
    chk("midfill_we", mem_we, 0);
    chk("midfill_addr", mem_addr, a[15:2]);
    #2;
    rst = 1'b0;
    #1;
    chk("midfill_req_drop", mem_req, 0);
    chk("midfill_ready", req_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midfill_ready_back", req_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    for (int i = 0; i < (1 << LAW); i++)
      mem[i] = {$urandom, $urandom};
    mem[14'h004] = 64'h4444_3333_2222_1111;
    model_reset();
    do_reset();

    access(1'b1, 16'h0010, 16'h0);
    access(1'b1, 16'h0012, 16'h0);
    access(1'b0, 16'h0011, 16'hBEEF);
    access(1'b1, 16'h0011, 16'h0);
    access(1'b1, 16'h0030, 16'h0);
    access(1'b0, 16'h0010, 16'h1234);
    access(1'b1, 16'h0030, 16'h0);
    access(1'b1, 16'h0050, 16'h0);
    chk("wb_word1", mem[14'h004][31:16], 16'hBEEF);
    access(1'b1, 16'h0030, 16'h0);

    do_reset();
    access(1'b1, 16'h0010, 16'h0);
    access(1'b1, 16'h0030, 16'h0);
    access(1'b0, 16'h0010, 16'h5A5A);
    access(1'b1, 16'h0030, 16'h0);
    access(1'b1, 16'h0050, 16'h0);
`ifdef WB_CACHE_PERF_EN
    chk("perf_hit_dir", perf_hit, 2);
    chk("perf_miss_dir", perf_miss, 3);
    chk("perf_wb_dir", perf_wb, 1);
`endif

    do_reset();
    access(1'b1, 16'h0010, 16'h0);
    access(1'b1, 16'h0030, 16'h0);
    access(1'b1, 16'h0010, 16'h0);
    access(1'b1, 16'h0050, 16'h0);
    access(1'b1, 16'h0011, 16'h0);
    access(1'b1, 16'h0032, 16'h0);

    for (int i = 0; i < 400; i++) begin
      a = {11'($urandom_range(0, 5)),
           3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), a, 16'($urandom));
    end
`ifdef WB_CACHE_PERF_EN
    chk("perf_hit_rand", perf_hit, e_hit);
    chk("perf_miss_rand", perf_miss, e_miss);
    chk("perf_wb_rand", perf_wb, e_wb);
`endif

    do_reset();
    reset_mid_fill(16'h0070);
    access(1'b1, 16'h0070, 16'h0);
    access(1'b1, 16'h0010, 16'h0);
    access(1'b1, 16'h0072, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
